// File: rtl/ibex_bcp_tag_enc_pkg.sv
// Shared types and the ELH candidate table for the bound-checking tag encoder.
// The table is the single source of the (L, H, lb, ub) encodings searched per exponent.
package ibex_bcp_tag_enc_pkg;

  localparam int unsigned BCP_ALEN  = 24;
  localparam int unsigned BCP_EMAX  = 22;
  localparam int unsigned BCP_NCAND = 7;

  typedef struct packed {
    logic [1:0] e_hi;
    logic [1:0] l;
    logic       h;
    logic [2:0] e_lo;
  } bcp_elh_tag_t;

  typedef enum logic [1:0] {
    BCP_ENC_IDLE,
    BCP_ENC_SEARCH,
    BCP_ENC_DONE
  } bcp_enc_state_e;

  // blk = 2^(e+blk_sh); the tolerant start aligns to blk * 2^span_sh.
  typedef struct packed {
    logic       valid;
    logic [1:0] l;
    logic       h;
    logic [3:0] lb;
    logic [3:0] ub;
    logic [1:0] blk_sh;
    logic [1:0] span_sh;
  } bcp_cand_t;

  localparam bcp_cand_t BCP_CAND_LO [BCP_NCAND] = '{
    '{valid: 1'b1, l: 2'd0, h: 1'b1, lb: 4'd0, ub: 4'd1, blk_sh: 2'd0, span_sh: 2'd0},
    '{valid: 1'b1, l: 2'd1, h: 1'b0, lb: 4'd0, ub: 4'd3, blk_sh: 2'd0, span_sh: 2'd2},
    '{valid: 1'b1, l: 2'd1, h: 1'b1, lb: 4'd1, ub: 4'd4, blk_sh: 2'd0, span_sh: 2'd2},
    '{valid: 1'b1, l: 2'd2, h: 1'b0, lb: 4'd0, ub: 4'd5, blk_sh: 2'd0, span_sh: 2'd3},
    '{valid: 1'b1, l: 2'd2, h: 1'b1, lb: 4'd3, ub: 4'd8, blk_sh: 2'd0, span_sh: 2'd3},
    '{valid: 1'b1, l: 2'd3, h: 1'b0, lb: 4'd0, ub: 4'd7, blk_sh: 2'd0, span_sh: 2'd3},
    '{valid: 1'b1, l: 2'd3, h: 1'b1, lb: 4'd1, ub: 4'd8, blk_sh: 2'd0, span_sh: 2'd3}
  };

  localparam bcp_cand_t BCP_CAND_TOP [BCP_NCAND] = '{
    '{valid: 1'b1, l: 2'd0, h: 1'b1, lb: 4'd0, ub: 4'd1, blk_sh: 2'd0, span_sh: 2'd0},
    '{valid: 1'b1, l: 2'd2, h: 1'b0, lb: 4'd0, ub: 4'd3, blk_sh: 2'd0, span_sh: 2'd2},
    '{valid: 1'b1, l: 2'd2, h: 1'b1, lb: 4'd1, ub: 4'd4, blk_sh: 2'd0, span_sh: 2'd2},
    '{valid: 1'b1, l: 2'd1, h: 1'b1, lb: 4'd0, ub: 4'd1, blk_sh: 2'd1, span_sh: 2'd2},
    '{valid: 1'b1, l: 2'd3, h: 1'b1, lb: 4'd0, ub: 4'd1, blk_sh: 2'd2, span_sh: 2'd3},
    '{valid: 1'b0, l: 2'd0, h: 1'b0, lb: 4'd0, ub: 4'd0, blk_sh: 2'd0, span_sh: 2'd0},
    '{valid: 1'b0, l: 2'd0, h: 1'b0, lb: 4'd0, ub: 4'd0, blk_sh: 2'd0, span_sh: 2'd0}
  };

  function automatic bcp_elh_tag_t bcp_make_tag(logic [4:0] e, logic [1:0] l, logic h);
    bcp_elh_tag_t t;
    t.e_hi = e[4:3];
    t.l    = l;
    t.h    = h;
    t.e_lo = e[2:0];
    return t;
  endfunction

endpackage

// File: rtl/ibex_bcp_tag_enc_if.sv
// Request/response handshake bundle between the tag-setting path and the ELH tag encoder.
interface ibex_bcp_tag_enc_if #(
  parameter int unsigned ALEN = ibex_bcp_tag_enc_pkg::BCP_ALEN
);

  logic            req_valid_i;
  logic            req_ready_o;
  logic [ALEN-1:0] req_base_i;
  logic [ALEN:0]   req_size_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [7:0]      resp_tag_o;
  logic [ALEN-1:0] resp_alloc_start_o;
  logic [ALEN-1:0] resp_alloc_end_o;
  logic            resp_err_o;

  modport slave (
    input  req_valid_i, req_base_i, req_size_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_tag_o, resp_alloc_start_o,
           resp_alloc_end_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_base_i, req_size_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_tag_o, resp_alloc_start_o,
           resp_alloc_end_o, resp_err_o
  );

endinterface

// File: rtl/ibex_bcp_elh_cand.sv
// Combinational evaluation of every ELH candidate at one exponent; reports the
// first (highest-priority) candidate whose allocated region covers [base, base+size).
module ibex_bcp_elh_cand
  import ibex_bcp_tag_enc_pkg::*;
#(
  parameter int unsigned ALEN = BCP_ALEN,
  parameter int unsigned EMax = BCP_EMAX
) (
  input  logic [4:0]      e_i,
  input  logic [ALEN-1:0] base_i,
  input  logic [ALEN:0]   size_i,
  output logic            hit_o,
  output logic [1:0]      l_o,
  output logic            h_o,
  output logic [ALEN-1:0] alloc_start_o,
  output logic [ALEN-1:0] alloc_end_o
);

  localparam int unsigned W = ALEN + 2;

  logic [W-1:0] base_w;
  logic [W-1:0] limit_w;

  assign base_w  = W'(base_i);
  assign limit_w = W'(base_i) + W'(size_i);

  always_comb begin
    bcp_cand_t    c;
    logic [5:0]   blk_amt;
    logic [5:0]   span_amt;
    logic [W-1:0] ts;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] hi_m1;

    hit_o         = 1'b0;
    l_o           = '0;
    h_o           = 1'b0;
    alloc_start_o = '0;
    alloc_end_o   = '0;
    c             = '0;
    blk_amt       = '0;
    span_amt      = '0;
    ts            = '0;
    lo            = '0;
    hi            = '0;
    hi_m1         = '0;

    for (int unsigned i = 0; i < BCP_NCAND; i++) begin
      c        = (e_i == 5'(EMax)) ? BCP_CAND_TOP[i] : BCP_CAND_LO[i];
      blk_amt  = 6'(e_i) + 6'(c.blk_sh);
      span_amt = blk_amt + 6'(c.span_sh);
      ts       = (base_w >> span_amt) << span_amt;
      lo       = ts + (W'(c.lb) << blk_amt);
      hi       = ts + (W'(c.ub) << blk_amt);
      hi_m1    = hi - W'(1);
      // hi >= 1 always, so a zero upper slice of hi-1 means the region ends at or below 2^ALEN
      if (!hit_o && c.valid && (lo <= base_w) && (limit_w <= hi) &&
          (hi_m1[W-1:ALEN] == '0)) begin
        hit_o         = 1'b1;
        l_o           = c.l;
        h_o           = c.h;
        alloc_start_o = lo[ALEN-1:0];
        alloc_end_o   = hi_m1[ALEN-1:0];
      end
    end
  end

endmodule

// File: rtl/ibex_bcp_tag_enc.sv
// Iterative ELH tag encoder: walks the exponent upward one per cycle until a
// candidate region covers the requested allocation, then holds the result.
module ibex_bcp_tag_enc
  import ibex_bcp_tag_enc_pkg::*;
#(
  parameter int unsigned ALEN = BCP_ALEN,
  parameter int unsigned EMax = BCP_EMAX
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  ibex_bcp_tag_enc_if.slave   bus
);

  localparam int unsigned W = ALEN + 2;
  localparam logic [W-1:0] SPACE = W'(1) << ALEN;

  bcp_enc_state_e  state_q, state_d;
  logic [4:0]      e_q, e_d;
  logic [ALEN-1:0] base_q, base_d;
  logic [ALEN:0]   size_q, size_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  bcp_elh_tag_t    tag_q, tag_d;
  logic [ALEN-1:0] start_q, start_d;
  logic [ALEN-1:0] last_q, last_d;
  logic            err_q, err_d;

  logic            cand_hit;
  logic [1:0]      cand_l;
  logic            cand_h;
  logic [ALEN-1:0] cand_start;
  logic [ALEN-1:0] cand_end;
  logic            bad_req;

  ibex_bcp_elh_cand #(
    .ALEN (ALEN),
    .EMax (EMax)
  ) u_cand (
    .e_i           (e_q),
    .base_i        (base_q),
    .size_i        (size_q),
    .hit_o         (cand_hit),
    .l_o           (cand_l),
    .h_o           (cand_h),
    .alloc_start_o (cand_start),
    .alloc_end_o   (cand_end)
  );

  assign bad_req = (size_q == '0) || ((W'(base_q) + W'(size_q)) > SPACE);

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    base_d  = base_q;
    size_d  = size_q;
    ready_d = ready_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    start_d = start_q;
    last_d  = last_q;
    err_d   = err_q;

    unique case (state_q)
      BCP_ENC_IDLE: begin
        if (bus.req_valid_i) begin
          base_d  = bus.req_base_i;
          size_d  = bus.req_size_i;
          e_d     = '0;
          ready_d = 1'b0;
          state_d = BCP_ENC_SEARCH;
        end
      end
      BCP_ENC_SEARCH: begin
        // An invalid request never becomes valid, so checking every cycle equals checking the first
        if (bad_req) begin
          err_d   = 1'b1;
          tag_d   = '0;
          start_d = '0;
          last_d  = '0;
          valid_d = 1'b1;
          state_d = BCP_ENC_DONE;
        end else if (cand_hit) begin
          err_d   = 1'b0;
          tag_d   = bcp_make_tag(e_q, cand_l, cand_h);
          start_d = cand_start;
          last_d  = cand_end;
          valid_d = 1'b1;
          state_d = BCP_ENC_DONE;
        end else if (e_q < 5'(EMax)) begin
          e_d = e_q + 5'd1;
        end else begin
          err_d   = 1'b1;
          tag_d   = '0;
          start_d = '0;
          last_d  = '0;
          valid_d = 1'b1;
          state_d = BCP_ENC_DONE;
        end
      end
      BCP_ENC_DONE: begin
        if (bus.resp_ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = BCP_ENC_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = BCP_ENC_IDLE;
      end
    endcase

    if (flush_i) begin
      valid_d = 1'b0;
      ready_d = 1'b1;
      state_d = BCP_ENC_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BCP_ENC_IDLE;
      e_q     <= '0;
      base_q  <= '0;
      size_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      tag_q   <= '0;
      start_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      base_q  <= base_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      start_q <= start_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o        = ready_q;
  assign bus.resp_valid_o       = valid_q;
  assign bus.resp_tag_o         = tag_q;
  assign bus.resp_alloc_start_o = start_q;
  assign bus.resp_alloc_end_o   = last_q;
  assign bus.resp_err_o         = err_q;

endmodule

// File: tb/tb_ibex_bcp_tag_enc.sv
// Directed bench for the ELH tag encoder: hand-computed tags, bounds and latencies.
module tb_ibex_bcp_tag_enc;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  int   vecs  = 0;
  int   errs  = 0;

  ibex_bcp_tag_enc_if #(.ALEN(24)) bus ();

  ibex_bcp_tag_enc #(
    .ALEN (24),
    .EMax (22)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] base;
    logic [24:0] size;
    int          lat;
    logic [7:0]  tag;
    logic [23:0] start;
    logic [23:0] last;
    logic        err;
  } vec_t;

  vec_t hit_tbl [7] = '{
    '{24'h000000, 25'h0000001,  2, 8'h08, 24'h000000, 24'h000000, 1'b0},
    '{24'h000003, 25'h0000001,  2, 8'h08, 24'h000003, 24'h000003, 1'b0},
    '{24'h000005, 25'h0000003,  2, 8'h18, 24'h000005, 24'h000007, 1'b0},
    '{24'h000100, 25'h0000010,  4, 8'h22, 24'h000100, 24'h000113, 1'b0},
    '{24'h000010, 25'h0000020,  5, 8'h33, 24'h000000, 24'h000037, 1'b0},
    '{24'hFFFFFF, 25'h0000001,  2, 8'h08, 24'hFFFFFF, 24'hFFFFFF, 1'b0},
    '{24'h000000, 25'h1000000, 24, 8'hBE, 24'h000000, 24'hFFFFFF, 1'b0}
  };

  vec_t err_tbl [3] = '{
    '{24'h000000, 25'h0000000, 2, 8'h00, 24'h000000, 24'h000000, 1'b1},
    '{24'hFFFFF0, 25'h0000020, 2, 8'h00, 24'h000000, 24'h000000, 1'b1},
    '{24'h000000, 25'h1000001, 2, 8'h00, 24'h000000, 24'h000000, 1'b1}
  };

  // Called #1 after an edge in IDLE; returns the cycle (relative to accept cycle T) of first resp_valid.
  task automatic run_req(input logic [23:0] b, input logic [24:0] s, output int lat);
    bus.req_base_i  = b;
    bus.req_size_i  = s;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (bus.resp_valid_o !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_resp();
    bus.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vecs++; if (bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", bus.req_ready_o); end
    vecs++; if (bus.resp_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", bus.resp_valid_o); end
    vecs++; if (bus.resp_tag_o !== 8'h00) begin errs++; $display("FAIL rst_tag: got %h want 00", bus.resp_tag_o); end
    vecs++; if (bus.resp_alloc_start_o !== 24'h0) begin errs++; $display("FAIL rst_start: got %h want 000000", bus.resp_alloc_start_o); end
    vecs++; if (bus.resp_alloc_end_o !== 24'h0) begin errs++; $display("FAIL rst_end: got %h want 000000", bus.resp_alloc_end_o); end
    vecs++; if (bus.resp_err_o !== 1'b0) begin errs++; $display("FAIL rst_err: got %b want 0", bus.resp_err_o); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors(input string name, input vec_t tbl [], input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      vecs++; if (bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL %s[%0d] ready: got %b want 1", name, i, bus.req_ready_o); end
      run_req(tbl[i].base, tbl[i].size, lat);
      vecs++; if (lat !== tbl[i].lat) begin errs++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, tbl[i].lat); end
      vecs++; if (bus.resp_tag_o !== tbl[i].tag) begin errs++; $display("FAIL %s[%0d] tag: got %h want %h", name, i, bus.resp_tag_o, tbl[i].tag); end
      vecs++; if (bus.resp_alloc_start_o !== tbl[i].start) begin errs++; $display("FAIL %s[%0d] start: got %h want %h", name, i, bus.resp_alloc_start_o, tbl[i].start); end
      vecs++; if (bus.resp_alloc_end_o !== tbl[i].last) begin errs++; $display("FAIL %s[%0d] end: got %h want %h", name, i, bus.resp_alloc_end_o, tbl[i].last); end
      vecs++; if (bus.resp_err_o !== tbl[i].err) begin errs++; $display("FAIL %s[%0d] err: got %b want %b", name, i, bus.resp_err_o, tbl[i].err); end
      release_resp();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_req(24'h000100, 25'h10, lat);
    vecs++; if (lat !== 4) begin errs++; $display("FAIL b2b latency: got %0d want 4", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vecs++; if (bus.resp_valid_o !== 1'b1 || bus.resp_tag_o !== 8'h22 || bus.resp_alloc_end_o !== 24'h000113)
        begin errs++; $display("FAIL b2b hold[%0d]: got v=%b tag=%h end=%h want v=1 tag=22 end=000113", i, bus.resp_valid_o, bus.resp_tag_o, bus.resp_alloc_end_o); end
      vecs++; if (bus.req_ready_o !== 1'b0) begin errs++; $display("FAIL b2b busy[%0d]: got ready=%b want 0", i, bus.req_ready_o); end
    end
    release_resp();
    vecs++; if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1)
      begin errs++; $display("FAIL b2b idle: got v=%b ready=%b want v=0 ready=1", bus.resp_valid_o, bus.req_ready_o); end
    bus.req_base_i  = 24'h000003;
    bus.req_size_i  = 25'h1;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    vecs++; if (bus.req_ready_o !== 1'b0) begin errs++; $display("FAIL b2b accept: got ready=%b want 0", bus.req_ready_o); end
    @(posedge clk); #1;
    vecs++; if (bus.resp_valid_o !== 1'b1 || bus.resp_tag_o !== 8'h08 || bus.resp_alloc_start_o !== 24'h000003)
      begin errs++; $display("FAIL b2b second: got v=%b tag=%h start=%h want v=1 tag=08 start=000003", bus.resp_valid_o, bus.resp_tag_o, bus.resp_alloc_start_o); end
    release_resp();
  endtask

  task automatic test_flush();
    logic seen;
    bus.req_base_i  = 24'h000000;
    bus.req_size_i  = 25'h400;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vecs++; if (bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0)
      begin errs++; $display("FAIL flush_search: got ready=%b v=%b want 0 0", bus.req_ready_o, bus.resp_valid_o); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vecs++; if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0)
      begin errs++; $display("FAIL flush_idle: got ready=%b v=%b want 1 0", bus.req_ready_o, bus.resp_valid_o); end
    seen = 1'b0;
    repeat (14) begin @(posedge clk); #1; if (bus.resp_valid_o !== 1'b0) seen = 1'b1; end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL flush_drop: got resp_valid seen=%b want 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.req_base_i  = 24'h000000;
    bus.req_size_i  = 25'h1000000;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    vecs++; if (bus.req_ready_o !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready_o); end
    vecs++; if (bus.resp_valid_o !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b want 0", bus.resp_valid_o); end
    vecs++; if (bus.resp_tag_o !== 8'h00 || bus.resp_err_o !== 1'b0)
      begin errs++; $display("FAIL rstmid_tag: got tag=%h err=%b want 00 0", bus.resp_tag_o, bus.resp_err_o); end
    vecs++; if (bus.resp_alloc_start_o !== 24'h0 || bus.resp_alloc_end_o !== 24'h0)
      begin errs++; $display("FAIL rstmid_bounds: got %h %h want 000000 000000", bus.resp_alloc_start_o, bus.resp_alloc_end_o); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (bus.resp_valid_o !== 1'b0) seen = 1'b1; end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL rstmid_noresp: got resp_valid seen=%b want 0", seen); end
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_base_i   = '0;
    bus.req_size_i   = '0;
    bus.resp_ready_i = 1'b0;
    test_reset();
    test_vectors("hit", hit_tbl, 7);
    test_vectors("err", err_tbl, 3);
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
